// File: rtl/feeder_pkg.sv
// feeder_pkg: shared definitions for frame_line_feeder and its line store.
// Holds the pacing FSM encoding, counter width helper and pad-word builder.
package feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRIME     = 3'd1,
    ST_WAIT_INTR = 3'd2,
    ST_LINE      = 3'd3,
    ST_PAD       = 3'd4,
    ST_DRAIN     = 3'd5,
    ST_DONE      = 3'd6
  } feeder_state_e;

  // Widest pixel word the pad-word builder can produce.
  localparam int unsigned PAD_WORD_MAX_W = 256;

  // Counter width able to index n distinct values (never below one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

  // PAD_VALUE copied into every channel slot, channel 0 in the LSBs.
  function automatic logic [PAD_WORD_MAX_W-1:0] replicate_pad(
    input int unsigned pad_value,
    input int unsigned pixel_size,
    input int unsigned channels
  );
    logic [PAD_WORD_MAX_W-1:0] word;
    word = '0;
    for (int unsigned i = 0; i < pixel_size * channels; i++) begin
      if (i < PAD_WORD_MAX_W) begin
        word[i] = pad_value[i % pixel_size];
      end else begin
        word = word;
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/feeder_line_store.sv
// feeder_line_store: one-line single-port RAM used to replay the last real
// line as bottom padding. A single address counter serves both the write
// pass and the replay pass; the read word for the next address is fetched
// every non-write cycle so the current word is always ready in rd_data_o.
module feeder_line_store
  import feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic             rd_adv_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int unsigned ADDR_W = cnt_width(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [WIDTH-1:0]  rd_data_q;

  // Address walks forward on every write or replayed word and wraps per line.
  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = '0;
    end else if (wr_en_i || rd_adv_i) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Single port: write the passing pixel, otherwise prefetch the next word.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[addr_q] <= wr_data_i;
    end else begin
      rd_data_q <= mem_q[addr_d];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/frame_line_feeder.sv
// frame_line_feeder: paces an upstream pixel stream into image_processing_core.
// Primes PRIME_LINES lines, then releases one line per rising edge of intr,
// appends PAD_LINES padding lines and waits for IMG_HEIGHT*LINE_LENGTH core
// outputs before pulsing frame_done.
// Build option: define REPLICATE_PAD_EN to pad by replaying the last real
// line instead of emitting PAD_VALUE.
module frame_line_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned LINE_LENGTH = 512,
  parameter int unsigned IMG_HEIGHT  = 512,
  parameter int unsigned PIXEL_SIZE  = 8,
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned PRIME_LINES = 4,
  parameter int unsigned PAD_LINES   = 2,
  parameter int unsigned PAD_VALUE   = 0
) (
  input  logic                                         axi_clk,
  input  logic                                         axi_rst_n,
  input  logic                                         start,
  input  logic [PIXEL_SIZE*CHANNELS-1:0]               pixel_in,
  input  logic                                         pixel_vin,
  output logic                                         feeder_ready,
  output logic [PIXEL_SIZE*CHANNELS-1:0]               pixel_out,
  output logic                                         pixel_vout,
  input  logic                                         core_ready,
  input  logic                                         intr,
  input  logic                                         core_vout,
  output logic                                         busy,
  output logic                                         frame_done,
  output logic [$clog2(IMG_HEIGHT+PAD_LINES+1)-1:0]    lines_sent
);

  localparam int unsigned PIX_W        = PIXEL_SIZE * CHANNELS;
  localparam int unsigned PIX_CNT_W    = cnt_width(LINE_LENGTH);
  localparam int unsigned LINES_W      = $clog2(IMG_HEIGHT + PAD_LINES + 1);
  localparam int unsigned PAD_CNT_W    = cnt_width(PAD_LINES + 1);
  localparam int unsigned TOTAL_OUT    = IMG_HEIGHT * LINE_LENGTH;
  localparam int unsigned OUT_CNT_W    = cnt_width(TOTAL_OUT + 1);
  localparam int unsigned PRIME_TARGET = (IMG_HEIGHT < PRIME_LINES) ? IMG_HEIGHT : PRIME_LINES;
  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(LINE_LENGTH - 1);

  feeder_state_e        state_q, state_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [LINES_W-1:0]   lines_q, lines_d;
  logic [PAD_CNT_W-1:0] pad_cnt_q, pad_cnt_d;
  logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic                 pending_q, pending_d;
  logic                 seg_last_q, seg_last_d;
  logic                 intr_q;
  logic [PIX_W-1:0]     pixel_out_q, pixel_out_d;
  logic                 pixel_vout_q, pixel_vout_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  logic             load_s, up_beat_s, pad_beat_s, beat_s, line_end_s;
  logic             intr_edge_s, seg_state_s, count_out_s;
  logic [PIX_W-1:0] pad_data_s, data_s;

  // The output register may take a new word when empty or being drained.
  assign load_s       = !pixel_vout_q || core_ready;
  assign feeder_ready = ((state_q == ST_PRIME) || (state_q == ST_LINE)) && load_s && !seg_last_q;
  assign up_beat_s    = feeder_ready && pixel_vin;
  assign pad_beat_s   = (state_q == ST_PAD) && load_s && !seg_last_q;
  assign beat_s       = up_beat_s || pad_beat_s;
  assign line_end_s   = beat_s && (pix_cnt_q == LAST_PIX);
  assign intr_edge_s  = intr && !intr_q;
  assign seg_state_s  = (state_q == ST_PRIME) || (state_q == ST_LINE) || (state_q == ST_PAD);
  assign count_out_s  = (state_q != ST_IDLE) && (state_q != ST_DONE) && core_vout &&
                        (out_cnt_q != OUT_CNT_W'(TOTAL_OUT));
  assign data_s       = up_beat_s ? pixel_in : pad_data_s;

`ifdef REPLICATE_PAD_EN
  logic store_wr_s, store_clear_s;

  assign store_wr_s    = up_beat_s && (lines_q == LINES_W'(IMG_HEIGHT - 1));
  assign store_clear_s = (state_q == ST_IDLE) || (state_q == ST_WAIT_INTR);

  feeder_line_store #(
    .DEPTH (LINE_LENGTH),
    .WIDTH (PIX_W)
  ) u_line_store (
    .clk_i     (axi_clk),
    .rst_ni    (axi_rst_n),
    .wr_en_i   (store_wr_s),
    .rd_adv_i  (pad_beat_s),
    .clear_i   (store_clear_s),
    .wr_data_i (pixel_in),
    .rd_data_o (pad_data_s)
  );
`else
  localparam logic [PAD_WORD_MAX_W-1:0] PAD_FULL = replicate_pad(PAD_VALUE, PIXEL_SIZE, CHANNELS);
  localparam logic [PIX_W-1:0]          PAD_WORD = PAD_FULL[PIX_W-1:0];

  assign pad_data_s = PAD_WORD;
`endif

  // Pacing FSM: next state, line/pad/output counters and output-register load.
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    lines_d      = lines_q;
    pad_cnt_d    = pad_cnt_q;
    out_cnt_d    = out_cnt_q;
    pending_d    = pending_q;
    seg_last_d   = seg_last_q;
    pixel_out_d  = pixel_out_q;
    pixel_vout_d = pixel_vout_q;

    if (beat_s) begin
      pixel_out_d = data_s;
    end else begin
      pixel_out_d = pixel_out_q;
    end

    if (load_s) begin
      pixel_vout_d = beat_s;
    end else begin
      pixel_vout_d = pixel_vout_q;
    end

    if (line_end_s) begin
      pix_cnt_d = '0;
      lines_d   = lines_q + LINES_W'(1);
    end else if (beat_s) begin
      pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
    end else begin
      pix_cnt_d = pix_cnt_q;
    end

    if (seg_state_s && intr_edge_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    if (count_out_s) begin
      out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
    end else begin
      out_cnt_d = out_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_PRIME;
          pix_cnt_d  = '0;
          lines_d    = '0;
          pad_cnt_d  = '0;
          out_cnt_d  = '0;
          pending_d  = 1'b0;
          seg_last_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (line_end_s && (lines_q == LINES_W'(PRIME_TARGET - 1))) begin
          if (IMG_HEIGHT < PRIME_LINES) begin
            state_d = (PAD_LINES != 32'd0) ? ST_PAD : ST_DRAIN;
          end else begin
            seg_last_d = 1'b1;
            state_d    = ST_WAIT_INTR;
          end
        end else begin
          state_d = ST_PRIME;
        end
      end
      ST_WAIT_INTR: begin
        if (pending_q || intr_edge_s) begin
          pending_d  = 1'b0;
          seg_last_d = 1'b0;
          if (lines_q < LINES_W'(IMG_HEIGHT)) begin
            state_d = ST_LINE;
          end else if (pad_cnt_q < PAD_CNT_W'(PAD_LINES)) begin
            state_d = ST_PAD;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          state_d = ST_WAIT_INTR;
        end
      end
      ST_LINE: begin
        if (line_end_s) begin
          seg_last_d = 1'b1;
          state_d    = ST_WAIT_INTR;
        end else begin
          state_d = ST_LINE;
        end
      end
      ST_PAD: begin
        if (line_end_s) begin
          pad_cnt_d  = pad_cnt_q + PAD_CNT_W'(1);
          seg_last_d = 1'b1;
          state_d    = ST_WAIT_INTR;
        end else begin
          state_d = ST_PAD;
        end
      end
      ST_DRAIN: begin
        if (out_cnt_q == OUT_CNT_W'(TOTAL_OUT)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);
    frame_done_d = (state_d == ST_DONE);
  end

  // State, counters, intr edge history and registered outputs.
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      state_q      <= ST_IDLE;
      pix_cnt_q    <= '0;
      lines_q      <= '0;
      pad_cnt_q    <= '0;
      out_cnt_q    <= '0;
      pending_q    <= 1'b0;
      seg_last_q   <= 1'b0;
      intr_q       <= 1'b0;
      pixel_out_q  <= '0;
      pixel_vout_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      lines_q      <= lines_d;
      pad_cnt_q    <= pad_cnt_d;
      out_cnt_q    <= out_cnt_d;
      pending_q    <= pending_d;
      seg_last_q   <= seg_last_d;
      intr_q       <= intr;
      pixel_out_q  <= pixel_out_d;
      pixel_vout_q <= pixel_vout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pixel_out  = pixel_out_q;
  assign pixel_vout = pixel_vout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign lines_sent = lines_q;

endmodule

// File: tb/tb_frame_line_feeder.sv
// tb_frame_line_feeder: randomized self-checking bench for frame_line_feeder.
// The reference is a frame-level model: the expected output is the source
// frame followed by the padding lines, and a line may only appear once the
// core has granted it (PRIME_LINES up front, one more per intr pulse).
module tb_frame_line_feeder;

  localparam int LL     = 8;
  localparam int IH     = 6;
  localparam int PS     = 8;
  localparam int CH     = 1;
  localparam int PL     = 4;
  localparam int PDL    = 2;
  localparam int PV     = 0;
  localparam int W      = PS * CH;
  localparam int NSRC   = IH * LL;
  localparam int NLINES = IH + PDL;
  localparam int NOUT   = NLINES * LL;
  localparam int LSW    = $clog2(IH + PDL + 1);

  logic           axi_clk;
  logic           axi_rst_n;
  logic           start;
  logic [W-1:0]   pixel_in;
  logic           pixel_vin;
  logic           feeder_ready;
  logic [W-1:0]   pixel_out;
  logic           pixel_vout;
  logic           core_ready;
  logic           intr;
  logic           core_vout;
  logic           busy;
  logic           frame_done;
  logic [LSW-1:0] lines_sent;

  int total;
  int bad;

  logic [W-1:0] src [NSRC];
  logic [W-1:0] exp_q [$];
  int   src_idx, out_cnt, intr_cnt, vout_sent, done_pulses, quiet;
  bit   bp_en, vin_rand, start_req, intr_req, prev_stall;
  logic [W-1:0] prev_out;

  frame_line_feeder #(
    .LINE_LENGTH (LL),
    .IMG_HEIGHT  (IH),
    .PIXEL_SIZE  (PS),
    .CHANNELS    (CH),
    .PRIME_LINES (PL),
    .PAD_LINES   (PDL),
    .PAD_VALUE   (PV)
  ) dut (
    .axi_clk      (axi_clk),
    .axi_rst_n    (axi_rst_n),
    .start        (start),
    .pixel_in     (pixel_in),
    .pixel_vin    (pixel_vin),
    .feeder_ready (feeder_ready),
    .pixel_out    (pixel_out),
    .pixel_vout   (pixel_vout),
    .core_ready   (core_ready),
    .intr         (intr),
    .core_vout    (core_vout),
    .busy         (busy),
    .frame_done   (frame_done),
    .lines_sent   (lines_sent)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Lines the core has granted so far.
  function automatic int lines_allowed();
    int n;
    n = PL + intr_cnt;
    return (n > NLINES) ? NLINES : n;
  endfunction

  // One clock: drive at negedge, observe the handshake that the next posedge takes.
  task automatic cycle();
    @(negedge axi_clk);
    start      = start_req;
    start_req  = 1'b0;
    intr       = intr_req;
    intr_req   = 1'b0;
    core_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    pixel_vin  = (src_idx < NSRC) && (!vin_rand || ($urandom_range(0, 3) != 0));
    pixel_in   = (src_idx < NSRC) ? src[src_idx] : W'($urandom);
    core_vout  = (vout_sent < NSRC) && (vout_sent < out_cnt) && ($urandom_range(0, 2) != 0);
    #1;
    if (prev_stall) begin
      check_val("hold_valid", 64'(pixel_vout), 64'(1));
      check_val("hold_data", 64'(pixel_out), 64'(prev_out));
    end
    if (feeder_ready && pixel_vin) src_idx++;
    if (pixel_vout && core_ready) begin
      if (exp_q.size() == 0) begin
        check_val("extra_beat", 64'(out_cnt + 1), 64'(NOUT));
      end else begin
        check_val("beat", 64'(pixel_out), 64'(exp_q.pop_front()));
      end
      out_cnt++;
      check_val("line_gate", 64'(out_cnt <= lines_allowed() * LL), 64'(1));
      quiet = 0;
    end else begin
      quiet++;
    end
    prev_stall = pixel_vout && !core_ready;
    prev_out   = pixel_out;
    if (frame_done) begin
      done_pulses++;
      check_val("done_after_vout", 64'(vout_sent), 64'(NSRC));
    end
    if (core_vout) vout_sent++;
    @(posedge axi_clk);
  endtask

  task automatic run_frame(input bit bp, input bit vr, input bit early, input bit busy_start,
                           input bit simul, input bit stall_chk, input int abort_at);
    bit stall_done, bs_done, early_done;
    logic [W-1:0] pad_val;
    for (int i = 0; i < NSRC; i++) src[i] = W'($urandom);
    if (stall_chk) begin
      for (int i = 0; i < LL; i++) src[(IH-1)*LL + i] = W'(32'h10 + i);
    end
    exp_q.delete();
    for (int i = 0; i < NSRC; i++) exp_q.push_back(src[i]);
    pad_val = '0;
    for (int c = 0; c < CH; c++) pad_val[c*PS +: PS] = PS'(PV);
    for (int p = 0; p < PDL; p++) begin
      for (int i = 0; i < LL; i++) begin
`ifdef REPLICATE_PAD_EN
        exp_q.push_back(src[(IH-1)*LL + i]);
`else
        exp_q.push_back(pad_val);
`endif
      end
    end
    src_idx = 0; out_cnt = 0; intr_cnt = 0; vout_sent = 0; done_pulses = 0; quiet = 0;
    bp_en = bp; vin_rand = vr; prev_stall = 1'b0;
    stall_done = 1'b0; bs_done = 1'b0; early_done = 1'b0;
    start_req = 1'b1;
    intr_req  = simul;
    for (int c = 0; c < 4000; c++) begin
      cycle();
      if (abort_at > 0 && out_cnt == abort_at) begin
        #2 axi_rst_n = 1'b0;
        #1;
        check_val("rst_vout", 64'(pixel_vout), 64'(0));
        check_val("rst_data", 64'(pixel_out), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_lines", 64'(lines_sent), 64'(0));
        check_val("rst_ready", 64'(feeder_ready), 64'(0));
        check_val("rst_done", 64'(frame_done), 64'(0));
        repeat (2) @(negedge axi_clk);
        axi_rst_n = 1'b1;
        return;
      end
      if (stall_chk && !stall_done && out_cnt == PL * LL) begin
        repeat (20) cycle();
        check_val("prime_stall_beats", 64'(out_cnt), 64'(PL * LL));
        check_val("prime_lines", 64'(lines_sent), 64'(PL));
        check_val("prime_busy", 64'(busy), 64'(1));
        stall_done = 1'b1;
      end
      if (early && !early_done && out_cnt == 5) begin
        intr_req = 1'b1;
        intr_cnt++;
        early_done = 1'b1;
      end else if (!intr_req && intr_cnt < NLINES - PL + 1 &&
                   out_cnt == lines_allowed() * LL && quiet >= 3) begin
        intr_req = 1'b1;
        intr_cnt++;
      end
      if (busy_start && !bs_done && out_cnt == 36) begin
        start_req = 1'b1;
        bs_done   = 1'b1;
      end
      if (done_pulses > 0) break;
    end
    repeat (10) cycle();
    check_val("frame_done_pulses", 64'(done_pulses), 64'(1));
    check_val("beats_total", 64'(out_cnt), 64'(NOUT));
    check_val("lines_sent_end", 64'(lines_sent), 64'(NLINES));
    check_val("busy_end", 64'(busy), 64'(0));
    check_val("exp_left", 64'(exp_q.size()), 64'(0));
    check_val("src_consumed", 64'(src_idx), 64'(NSRC));
  endtask

  initial begin
    total = 0; bad = 0;
    axi_rst_n = 1'b0; start = 1'b0; pixel_in = '0; pixel_vin = 1'b0;
    core_ready = 1'b0; intr = 1'b0; core_vout = 1'b0;
    start_req = 1'b0; intr_req = 1'b0; prev_stall = 1'b0;
    src_idx = 0; out_cnt = 0; intr_cnt = 0; vout_sent = 0; done_pulses = 0; quiet = 0;
    repeat (3) @(negedge axi_clk);
    check_val("reset_vout", 64'(pixel_vout), 64'(0));
    check_val("reset_data", 64'(pixel_out), 64'(0));
    check_val("reset_busy", 64'(busy), 64'(0));
    check_val("reset_done", 64'(frame_done), 64'(0));
    check_val("reset_lines", 64'(lines_sent), 64'(0));
    check_val("reset_ready", 64'(feeder_ready), 64'(0));
    axi_rst_n = 1'b1;
    repeat (2) @(negedge axi_clk);

    // nominal, with an intr edge in the same IDLE cycle as start (must be dropped)
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    // backpressure and bursty upstream
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // early intr during PRIME
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    // abort after 20 beats, then a fresh frame from beat 0
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // start while busy is ignored
    run_frame(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
